mod_n_counter: RTL



---
 rtl/mod_n_counter_if.sv | 23 ++
 rtl/mod_n_counter.sv | 80 ++++++++
 2 files changed

// File: rtl/mod_n_counter_if.sv
// Bus bundle for mod_n_counter: control/load inputs and count/status outputs.
// master = the controlling logic, slave = the counter itself.
interface mod_n_counter_if #(
    parameter int WIDTH = 4
) ();
    logic             en;
    logic             up;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] q;
    logic             wrap;
    logic             err;

    modport master (
        output en, up, load, load_val,
        input  q, wrap, err
    );

    modport slave (
        input  en, up, load, load_val,
        output q, wrap, err
    );
endinterface

// File: rtl/mod_n_counter.sv
// Synchronous modulo-N up/down counter with parallel load, registered wrap
// pulse for cascading, and a sticky flag for out-of-range loads.
module mod_n_counter #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 10
) (
    input  logic           clk,
    input  logic           reset,
    mod_n_counter_if.slave bus
);
    if (MODULUS < 2 || MODULUS > (1 << WIDTH)) begin : g_bad_modulus
        $error("mod_n_counter: MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
    end

    // One extra bit so MODULUS == 2**WIDTH is representable.
    localparam logic [WIDTH:0] MOD_W  = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH:0] MOD_M1 = (WIDTH+1)'(MODULUS - 1);

    logic [WIDTH-1:0] q_q, q_d;
    logic             wrap_q, wrap_d;
    logic             err_q, err_d;

    logic [WIDTH:0]   q_ext;
    logic [WIDTH:0]   load_ext;
    logic [WIDTH:0]   step_ext;

    assign q_ext    = {1'b0, q_q};
    assign load_ext = {1'b0, bus.load_val};

    // Next-state: load beats count beats hold; wrap is detected by comparing
    // the current value against the end points, never by the carry.
    always_comb begin
        q_d      = q_q;
        wrap_d   = 1'b0;
        err_d    = err_q;
        step_ext = q_ext;
        if (bus.load) begin
            if (load_ext < MOD_W) begin
                q_d = bus.load_val;
            end else begin
                err_d = 1'b1;
            end
        end else if (bus.en) begin
            if (bus.up) begin
                if (q_ext == MOD_M1) begin
                    step_ext = '0;
                    wrap_d   = 1'b1;
                end else begin
                    step_ext = q_ext + 1'b1;
                end
            end else begin
                if (q_ext == '0) begin
                    step_ext = MOD_M1;
                    wrap_d   = 1'b1;
                end else begin
                    step_ext = q_ext - 1'b1;
                end
            end
            // Guard keeps q inside 0..MODULUS-1 even if state were corrupted.
            q_d = (step_ext < MOD_W) ? step_ext[WIDTH-1:0] : '0;
        end
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            q_q    <= '0;
            wrap_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            q_q    <= q_d;
            wrap_q <= wrap_d;
            err_q  <= err_d;
        end
    end

    assign bus.q    = q_q;
    assign bus.wrap = wrap_q;
    assign bus.err  = err_q;
endmodule
